conv_accumulate: RTL

- Downstream stage of the 5-tap convolution multiplier.
- Consumes its six signed Q16.16 products per beat (bias product plus five tap products) and sums them in an adder stage.
- Accumulates the sums across Num_channels input-channel beats, then rescales to Q8.8 with rounding and saturation, applies optional ReLU and presents one output sample per group with a valid/ready handshake.

---
 rtl/conv_pkg.sv | 10 +
 rtl/conv_accumulate_if.sv | 31 +++
 rtl/q_rescale_sat.sv | 30 +++
 rtl/conv_accumulate.sv | 116 +++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Fixed-point constants shared by the convolution datapath stages
// (multiplier, accumulate, pooling).
package conv_pkg;
    localparam int Bit_width   = 16;
    localparam int Frac_bits   = 8;
    localparam int Prod_width  = 2 * Bit_width;
    localparam int q88_max     = (1 << (Bit_width - 1)) - 1;
    localparam int q88_min     = -(1 << (Bit_width - 1));
    localparam int round_const = 1 << (Frac_bits - 1);
endpackage

// File: rtl/conv_accumulate_if.sv
// Beat input and sample output bundle between the multiplier stage,
// the accumulate stage and its downstream consumer.
interface conv_accumulate_if;
    import conv_pkg::*;

    logic [1:0]                   Enable;
    logic signed [Prod_width-1:0] mul_result_0;
    logic signed [Prod_width-1:0] mul_result_1;
    logic signed [Prod_width-1:0] mul_result_2;
    logic signed [Prod_width-1:0] mul_result_3;
    logic signed [Prod_width-1:0] mul_result_4;
    logic signed [Prod_width-1:0] mul_result_5;
    logic                         relu_en;
    logic                         in_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [Bit_width-1:0]  out_data;
    logic [7:0]                   chan_idx;

    modport master (
        output Enable, mul_result_0, mul_result_1, mul_result_2,
               mul_result_3, mul_result_4, mul_result_5, relu_en, out_ready,
        input  in_ready, out_valid, out_data, chan_idx
    );

    modport slave (
        input  Enable, mul_result_0, mul_result_1, mul_result_2,
               mul_result_3, mul_result_4, mul_result_5, relu_en, out_ready,
        output in_ready, out_valid, out_data, chan_idx
    );
endinterface

// File: rtl/q_rescale_sat.sv
// Combinational Q(acc) -> Q8.8 rescale: round half toward +inf, arithmetic
// shift, saturate to the Q8.8 range and optionally clamp negatives to zero.
module q_rescale_sat
    import conv_pkg::*;
#(
    parameter int Acc_width = 48
) (
    input  logic signed [Acc_width-1:0] acc,
    input  logic                        relu_en,
    output logic signed [Bit_width-1:0] result
);
    localparam logic signed [Acc_width-1:0] sat_hi   = Acc_width'(q88_max);
    localparam logic signed [Acc_width-1:0] sat_lo   = Acc_width'(q88_min);
    localparam logic signed [Acc_width-1:0] half_lsb = Acc_width'(round_const);

    logic signed [Acc_width-1:0] rounded;

    always_comb begin
        rounded = (acc + half_lsb) >>> Frac_bits;
        if (relu_en && (rounded < 0)) begin
            result = '0;
        end else if (rounded > sat_hi) begin
            result = Bit_width'(q88_max);
        end else if (rounded < sat_lo) begin
            result = Bit_width'(q88_min);
        end else begin
            result = rounded[Bit_width-1:0];
        end
    end
endmodule

// File: rtl/conv_accumulate.sv
// Sums the six products of each beat, accumulates Num_channels beats per
// group, then rescales to Q8.8 and presents one sample per group.
module conv_accumulate
    import conv_pkg::*;
#(
    parameter int Num_channels = 4,
    parameter int Acc_width    = 48
) (
    input logic              clk,
    input logic              rst,
    conv_accumulate_if.slave bus
);
    typedef logic signed [Acc_width-1:0] acc_t;

    localparam logic [7:0] last_idx = 8'(Num_channels - 1);

    logic       advance;
    logic       accept;
    logic       first;
    logic       last;
    logic [7:0] chan_idx;
    acc_t       bias_term;
    acc_t       part_a;
    acc_t       part_b;

    logic       s0_valid, s0_first, s0_last, s0_relu;
    acc_t       s0_part_a, s0_part_b;
    logic       s1_valid, s1_first, s1_last, s1_relu;
    acc_t       s1_sum;
    logic       s2_valid, s2_last, s2_relu;
    acc_t       acc;

    logic                        out_valid;
    logic signed [Bit_width-1:0] out_data;
    logic signed [Bit_width-1:0] rescaled;

    assign advance = !out_valid || bus.out_ready;
    assign accept  = (bus.Enable != 2'b00) && advance;
    assign first   = (chan_idx == 8'd0);
    assign last    = (chan_idx == last_idx);

    // The six-way add is split over two register levels to keep it off the input path.
    always_comb begin
        bias_term = first ? acc_t'(bus.mul_result_0) : '0;
        part_a    = bias_term + acc_t'(bus.mul_result_1) + acc_t'(bus.mul_result_2);
        part_b    = acc_t'(bus.mul_result_3) + acc_t'(bus.mul_result_4)
                  + acc_t'(bus.mul_result_5);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chan_idx  <= '0;
            s0_valid  <= 1'b0;
            s0_first  <= 1'b0;
            s0_last   <= 1'b0;
            s0_relu   <= 1'b0;
            s0_part_a <= '0;
            s0_part_b <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_relu   <= 1'b0;
            s1_sum    <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_relu   <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            s0_valid <= accept;
            if (accept) begin
                chan_idx  <= last ? 8'd0 : chan_idx + 8'd1;
                s0_part_a <= part_a;
                s0_part_b <= part_b;
                s0_first  <= first;
                s0_last   <= last;
                s0_relu   <= bus.relu_en;
            end

            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_sum   <= s0_part_a + s0_part_b;
                s1_first <= s0_first;
                s1_last  <= s0_last;
                s1_relu  <= s0_relu;
            end

            // A first beat restarts the group sum instead of adding to the stale one.
            s2_valid <= s1_valid;
            if (s1_valid) begin
                acc     <= (s1_first ? '0 : acc) + s1_sum;
                s2_last <= s1_last;
                s2_relu <= s1_relu;
            end

            out_valid <= s2_valid && s2_last;
            if (s2_valid && s2_last) begin
                out_data <= rescaled;
            end
        end
    end

    q_rescale_sat #(
        .Acc_width(Acc_width)
    ) u_rescale (
        .acc    (acc),
        .relu_en(s2_relu),
        .result (rescaled)
    );

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.chan_idx  = chan_idx;
endmodule
